// File: rtl/ppdu_tx_sequencer.sv
// 802.11a PPDU bit sequencer feeding the scrambler: SIGNAL, SERVICE, PSDU and tail/pad bits.
// Build option: define UNDERRUN_ABORT_EN to abort the PPDU on a PSDU byte underrun instead of zero-filling.
module ppdu_tx_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        start,
    input  logic [3:0]  rate_in,
    input  logic [11:0] length_in,
    input  logic [6:0]  seed_in,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        scr_reset_n,
    output logic [6:0]  scr_seed,
    output logic        scr_data,
    output logic [7:0]  tail_pad_length,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned N_TAIL    = 6;
    localparam int unsigned N_SERVICE = 16;
    localparam int unsigned CW        = 16;
    localparam int unsigned SIG_BITS  = 24;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_SIGNAL, S_DATA, S_TAIL, S_DONE
    } state_t;

    state_t        state, nxt_state;
    logic [CW-1:0] cnt, nxt_cnt, cnt_inc;
    logic [CW-1:0] acc, acc_d;
    logic [3:0]    rate_q, rate_d;
    logic [11:0]   len_q, len_d;
    logic [7:0]    dbps_q, dbps_d, dbps_in;
    logic [11:0]   slot_cnt, slot_d;
    logic [7:0]    hold, hold_d, cur, cur_d;
    logic          hold_vld, hold_vld_d;
    logic [6:0]    seed_d;
    logic [7:0]    tpl_d;
    logic          ready_d, rstn_d, data_d, busy_d, done_d, error_d;
    logic          xfer, boundary, in_flow, nxt_in_flow;
    logic [CW-1:0] nb, data_last;
    logic [16:0]   sig_low;
    logic [SIG_BITS-1:0] sig_vec;

    // Data bits per OFDM symbol for each legal RATE code; 0 marks an illegal code
    always_comb begin
        dbps_in = 8'd0;
        case (rate_in)
            4'b1101: dbps_in = 8'd24;
            4'b1111: dbps_in = 8'd36;
            4'b0101: dbps_in = 8'd48;
            4'b0111: dbps_in = 8'd72;
            4'b1001: dbps_in = 8'd96;
            4'b1011: dbps_in = 8'd144;
            4'b0001: dbps_in = 8'd192;
            4'b0011: dbps_in = 8'd216;
            default: dbps_in = 8'd0;
        endcase
    end

    // SIGNAL field in transmit order: R1..R4, reserved, LENGTH LSB first, parity, six zeros
    assign sig_low = {len_q, 1'b0, rate_q[0], rate_q[1], rate_q[2], rate_q[3]};
    assign sig_vec = {6'd0, ^sig_low, sig_low};

    assign xfer      = byte_ready & byte_valid;
    assign cnt_inc   = cnt + 16'd1;
    assign nb        = 16'(N_SERVICE + N_TAIL) + {1'b0, len_q, 3'b000};
    assign data_last = 16'(N_SERVICE - 1) + {1'b0, len_q, 3'b000};
    assign in_flow   = (state inside {S_CALC, S_SIGNAL, S_DATA});
    // A new PSDU byte starts on the next bit: SERVICE and PSDU lengths are byte multiples
    assign boundary  = (state == S_DATA) && (cnt != data_last) &&
                       (cnt_inc >= 16'(N_SERVICE)) && (cnt_inc[2:0] == 3'd0);

    always_comb begin
        nxt_state  = state;
        acc_d      = acc;
        rate_d     = rate_q;
        len_d      = len_q;
        dbps_d     = dbps_q;
        slot_d     = slot_cnt;
        hold_d     = hold;
        hold_vld_d = hold_vld;
        cur_d      = cur;
        seed_d     = scr_seed;
        tpl_d      = tail_pad_length;
        error_d    = 1'b0;
        data_d     = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    if (dbps_in == 8'd0 || length_in == 12'd0) begin
                        error_d = 1'b1;
                    end else begin
                        rate_d    = rate_in;
                        len_d     = length_in;
                        dbps_d    = dbps_in;
                        seed_d    = seed_in;
                        acc_d     = '0;
                        slot_d    = '0;
                        nxt_state = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (acc >= nb) begin
                    tpl_d     = 8'(N_TAIL - 1) + 8'(acc - nb);
                    nxt_state = S_SIGNAL;
                end else begin
                    acc_d = acc + 16'(dbps_q);
                end
            end
            S_SIGNAL: if (cnt == 16'(SIG_BITS - 1)) nxt_state = S_DATA;
            S_DATA:   if (cnt == data_last) nxt_state = S_TAIL;
            S_TAIL:   if (cnt == 16'(tail_pad_length)) nxt_state = S_DONE;
            S_DONE:   nxt_state = S_IDLE;
            default:  nxt_state = S_IDLE;
        endcase

        // Byte buffer: a byte arriving on a boundary cycle bypasses the holding register
        if (boundary) begin
            if (hold_vld || xfer) begin
                cur_d      = hold_vld ? hold : byte_data;
                hold_vld_d = 1'b0;
                if (xfer) slot_d = slot_cnt + 12'd1;
            end else begin
                cur_d   = 8'd0;
                error_d = 1'b1;
                slot_d  = slot_cnt + 12'd1;
`ifdef UNDERRUN_ABORT_EN
                nxt_state = S_IDLE;
`endif
            end
        end else if (xfer) begin
            hold_d     = byte_data;
            hold_vld_d = 1'b1;
            slot_d     = slot_cnt + 12'd1;
        end

        if (nxt_state == S_IDLE || nxt_state == S_DONE) begin
            hold_vld_d = 1'b0;
            cur_d      = 8'd0;
        end

        nxt_cnt = (nxt_state != state || state == S_IDLE) ? '0 : cnt_inc;

        // Registered outputs describe the cycle being entered
        case (nxt_state)
            S_SIGNAL: data_d = sig_vec[nxt_cnt[4:0]];
            S_DATA:   data_d = (nxt_cnt >= 16'(N_SERVICE)) ? cur_d[nxt_cnt[2:0]] : 1'b0;
            default:  data_d = 1'b0;
        endcase
    end

    assign nxt_in_flow = (nxt_state inside {S_CALC, S_SIGNAL, S_DATA});
    assign ready_d = in_flow && nxt_in_flow && !hold_vld_d && (slot_d < len_q);
    assign rstn_d  = (nxt_state inside {S_SIGNAL, S_DATA, S_TAIL});
    assign busy_d  = (nxt_state != S_IDLE);
    assign done_d  = (nxt_state == S_DONE);

    // State and output registers
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state           <= S_IDLE;
            cnt             <= '0;
            acc             <= '0;
            rate_q          <= '0;
            len_q           <= '0;
            dbps_q          <= '0;
            slot_cnt        <= '0;
            hold            <= '0;
            hold_vld        <= 1'b0;
            cur             <= '0;
            scr_seed        <= '0;
            tail_pad_length <= '0;
            byte_ready      <= 1'b0;
            scr_reset_n     <= 1'b0;
            scr_data        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
        end else begin
            state           <= nxt_state;
            cnt             <= nxt_cnt;
            acc             <= acc_d;
            rate_q          <= rate_d;
            len_q           <= len_d;
            dbps_q          <= dbps_d;
            slot_cnt        <= slot_d;
            hold            <= hold_d;
            hold_vld        <= hold_vld_d;
            cur             <= cur_d;
            scr_seed        <= seed_d;
            tail_pad_length <= tpl_d;
            byte_ready      <= ready_d;
            scr_reset_n     <= rstn_d;
            scr_data        <= data_d;
            busy            <= busy_d;
            done            <= done_d;
            error           <= error_d;
        end
    end

endmodule

// File: tb/tb_ppdu_tx_sequencer.sv
// Randomized bench for ppdu_tx_sequencer; expected bit streams come from a PPDU-level model.
// Build option UNDERRUN_ABORT_EN selects the abort expectations for the underrun case.
module tb_ppdu_tx_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  rate_in = '0;
    logic [11:0] length_in = '0;
    logic [6:0]  seed_in = '0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, scr_reset_n, scr_data, busy, done, error;
    logic [6:0]  scr_seed;
    logic [7:0]  tail_pad_length;

    ppdu_tx_sequencer dut (
        .Clk(Clk), .Reset(Reset), .start(start), .rate_in(rate_in),
        .length_in(length_in), .seed_in(seed_in), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_ready(byte_ready), .scr_reset_n(scr_reset_n),
        .scr_seed(scr_seed), .scr_data(scr_data), .tail_pad_length(tail_pad_length),
        .busy(busy), .done(done), .error(error)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    logic       obs_q[$];
    logic       exp_q[$];
    logic [7:0] bytes[$];
    int         err_seen, done_seen, exp_tpl;
    logic [7:0] tpl_seen;
    logic [6:0] seed_seen;

    logic [3:0] rate_tab[8] = '{4'b1101, 4'b1111, 4'b0101, 4'b0111,
                                4'b1001, 4'b1011, 4'b0001, 4'b0011};
    int         dbps_tab[8] = '{24, 36, 48, 72, 96, 144, 192, 216};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Observe the scrambler interface once per cycle, away from the active edge
    task automatic sample();
        if (scr_reset_n) begin
            if (obs_q.size() == 0) begin
                tpl_seen  = tail_pad_length;
                seed_seen = scr_seed;
            end
            obs_q.push_back(scr_data);
        end
        if (error) err_seen++;
        if (done)  done_seen++;
    endtask

    function automatic int dbps_of(input logic [3:0] r);
        int d = 0;
        for (int i = 0; i < 8; i++) if (rate_tab[i] == r) d = dbps_tab[i];
        return d;
    endfunction

    // Whole-PPDU model: SIGNAL, SERVICE, PSDU, then tail plus pad up to a symbol multiple
    task automatic build_expected(input logic [3:0] r, input int len);
        int nd, nbits, nsym, npad;
        logic p;
        logic [11:0] l12;
        exp_q.delete();
        l12 = 12'(len);
        p = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(r[3-k]);
            p ^= r[3-k];
        end
        exp_q.push_back(1'b0);
        for (int k = 0; k < 12; k++) begin
            exp_q.push_back(l12[k]);
            p ^= l12[k];
        end
        exp_q.push_back(p);
        repeat (6)  exp_q.push_back(1'b0);
        repeat (16) exp_q.push_back(1'b0);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = bytes[i];
            for (int k = 0; k < 8; k++) exp_q.push_back(b[k]);
        end
        nd    = dbps_of(r);
        nbits = 22 + 8 * len;
        nsym  = (nbits + nd - 1) / nd;
        npad  = nsym * nd - nbits;
        exp_tpl = 5 + npad;
        repeat (6 + npad) exp_q.push_back(1'b0);
    endtask

    task automatic fill_bytes(input int len);
        bytes.delete();
        for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
    endtask

    // Launch one PPDU, feed bytes until the sequencer goes idle, and score it against the model
    task automatic run_ppdu(input string tag, input logic [3:0] r, input int len,
                            input logic [6:0] sd, input int vpct, input int drop_at,
                            input int exp_err, input int exp_done, input int exp_bits,
                            input bit hold_start);
        int idx, nbad, n, want_bits;
        bit seen_busy, finished;
        build_expected(r, len);
        want_bits = (exp_bits < 0) ? exp_q.size() : exp_bits;
        obs_q.delete();
        err_seen = 0; done_seen = 0; idx = 0; seen_busy = 0; finished = 0;
        @(posedge Clk); #1;
        rate_in = r; length_in = 12'(len); seed_in = sd; start = 1'b1;
        for (int c = 0; c < 40000 && !finished; c++) begin
            @(negedge Clk);
            sample();
            if (byte_valid && byte_ready) idx++;
            if (busy) seen_busy = 1;
            else if (seen_busy || c > 3) finished = 1;
            @(posedge Clk); #1;
            start = hold_start && (done_seen == 0);
            rate_in = 4'($urandom); length_in = 12'($urandom); seed_in = 7'($urandom);
            byte_valid = (idx < len) && (idx < drop_at) && (int'($urandom_range(99, 0)) < vpct);
            byte_data  = (idx < len) ? bytes[idx] : 8'($urandom);
        end
        start = 1'b0;
        byte_valid = 1'b0;
        check({tag, "_timeout"}, 32'(finished), 32'd1);
        check({tag, "_bits"}, obs_q.size(), want_bits);
        n = (obs_q.size() < want_bits) ? obs_q.size() : want_bits;
        nbad = 0;
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) nbad++;
        check({tag, "_badbits"}, nbad, 0);
        check({tag, "_tpl"}, 32'(tpl_seen), exp_tpl);
        check({tag, "_seed"}, 32'(seed_seen), 32'(sd));
        check({tag, "_err"}, err_seen, exp_err);
        check({tag, "_done"}, done_seen, exp_done);
        check({tag, "_bytes"}, idx, (drop_at < len) ? drop_at : len);
    endtask

    initial begin
        logic [23:0] sig;
        logic [7:0]  b;
        int          r_i, len;

        repeat (3) @(posedge Clk);
        #1 Reset = 1'b1;
        @(negedge Clk);
        check("rst_outputs", {24'd0, byte_ready, scr_reset_n, scr_data, busy, done, error, 2'b0}, 32'd0);
        check("rst_tpl_seed", {17'd0, tail_pad_length, scr_seed}, 32'd0);

        // Single-byte PPDU at the lowest rate
        bytes.delete();
        bytes.push_back(8'hA5);
        run_ppdu("t1", 4'b1101, 1, 7'h5D, 100, 9999, 0, 1, -1, 0);
        check("t1_tpl_const", 32'(tpl_seen), 32'd23);
        sig = '0;
        b = '0;
        if (obs_q.size() >= 48) begin
            for (int k = 0; k < 24; k++) sig[k] = obs_q[k];
            for (int k = 0; k < 8; k++) b[k] = obs_q[40 + k];
        end
        check("t1_signal", 32'(sig), 32'h00002B);
        check("t1_psdu", 32'(b), 32'hA5);

        // Long PPDU at the highest rate
        fill_bytes(100);
        run_ppdu("t2", 4'b0011, 100, 7'h7F, 100, 9999, 0, 1, -1, 0);
        check("t2_total", obs_q.size(), 888);
        check("t2_tpl_const", 32'(tpl_seen), 32'd47);

        // Illegal rate and zero length are rejected with a single error pulse
        @(posedge Clk); #1;
        rate_in = 4'b0000; length_in = 12'd5; start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
        @(negedge Clk);
        check("t3_error", 32'(error), 32'd1);
        check("t3_busy", 32'(busy), 32'd0);
        @(negedge Clk);
        check("t3_error_gone", 32'(error), 32'd0);
        check("t3_rstn", 32'(scr_reset_n), 32'd0);
        @(posedge Clk); #1;
        rate_in = 4'b1101; length_in = 12'd0; start = 1'b1;
        @(posedge Clk); #1 start = 1'b0;
        @(negedge Clk);
        check("t3_len0_error", 32'(error), 32'd1);
        check("t3_len0_busy", 32'(busy), 32'd0);

        // Source stops after three of four bytes
        fill_bytes(4);
        bytes[3] = 8'h00;
`ifdef UNDERRUN_ABORT_EN
        run_ppdu("t4", 4'b1101, 4, 7'h11, 100, 3, 1, 0, 64, 0);
`else
        run_ppdu("t4", 4'b1101, 4, 7'h11, 100, 3, 1, 1, -1, 0);
        check("t4_total", obs_q.size(), 24 + 48 + exp_tpl + 1);
`endif

        // Reset asserted in DATA cycle 10
        fill_bytes(20);
        obs_q.delete();
        err_seen = 0; done_seen = 0;
        @(posedge Clk); #1;
        rate_in = 4'b1101; length_in = 12'd20; seed_in = 7'h2A; start = 1'b1;
        for (int c = 0; c < 2000 && obs_q.size() < 34; c++) begin
            @(negedge Clk);
            sample();
            @(posedge Clk); #1;
            start = 1'b0;
            byte_valid = 1'b1;
            byte_data = 8'($urandom);
        end
        check("t5_reached", obs_q.size(), 34);
        #1 Reset = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        byte_valid = 1'b0;
        @(negedge Clk);
        check("t5_outputs", {24'd0, byte_ready, scr_reset_n, scr_data, busy, done, error, 2'b0}, 32'd0);
        check("t5_tpl_seed", {17'd0, tail_pad_length, scr_seed}, 32'd0);
        for (int c = 0; c < 60; c++) begin
            @(negedge Clk);
            sample();
        end
        check("t5_no_done", done_seen, 0);
        check("t5_idle", 32'(busy), 32'd0);
        fill_bytes(7);
        run_ppdu("t5_after", 4'b0101, 7, 7'h33, 100, 9999, 0, 1, -1, 0);

        // start held high with changing inputs for the whole PPDU
        fill_bytes(9);
        run_ppdu("t6", 4'b0111, 9, 7'h4C, 100, 9999, 0, 1, -1, 1);
        repeat (3) @(negedge Clk);
        check("t6_idle_after", 32'(busy), 32'd0);

        // Randomized PPDUs with a stalling byte source
        for (int t = 0; t < 10; t++) begin
            r_i = int'($urandom_range(7, 0));
            len = int'($urandom_range(40, 1));
            fill_bytes(len);
            run_ppdu("rnd", rate_tab[r_i], len, 7'($urandom_range(127, 1)), 90, 9999, 0, 1, -1, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
